// File: rtl/cnt_monitor_pkg.sv
// Shared definitions for the counter monitor: FSM states, event codes and the event record.
package cnt_monitor_pkg;

    localparam int unsigned CNT_IN_W   = 4;
    localparam int unsigned EVT_CODE_W = 2;
    localparam int unsigned EVT_W      = EVT_CODE_W + CNT_IN_W;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam logic [EVT_CODE_W-1:0] EVT_WRAP = 2'b01;
    localparam logic [EVT_CODE_W-1:0] EVT_ERR  = 2'b10;
    localparam logic [EVT_CODE_W-1:0] EVT_LOCK = 2'b11;

    typedef struct packed {
        logic [EVT_CODE_W-1:0] code;
        logic [CNT_IN_W-1:0]   value;
    } evt_t;

    // Expected successor of a 4-bit counter value (wraps 15 -> 0).
    function automatic logic [CNT_IN_W-1:0] succ(input logic [CNT_IN_W-1:0] v);
        return v + CNT_IN_W'(1);
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// Event FIFO: power-of-two depth, synchronous active-low reset.
// Ports: clk, rst (sync, active-low), push/push_data, pop/pop_data (head), full, empty.
// A push while full is accepted only when a pop happens in the same cycle.
module evt_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    // Nothing moves during a reset cycle.
    assign do_pop  = rst & pop & ~empty;
    assign do_push = rst & push & (~full | do_pop);

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_data = mem[rd_ptr];

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage, no reset needed: contents are only observed below count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/cnt_monitor.sv
// Monitors a free-running 4-bit counter: locks after two consecutive correct steps,
// counts wraps and sequence errors while locked, and queues events for a consumer.
// Ports: clk, rst (sync, active-low), cnt_in; locked, wrap_cnt, err_cnt, ovf;
//        event stream evt_valid/evt_ready/evt_code/evt_value.
module cnt_monitor
    import cnt_monitor_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       cnt_in,
    output logic             locked,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             ovf,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_code,
    output logic [3:0]       evt_value
);

    state_t            state;
    state_t            state_nxt;
    logic              run;
    logic              run_nxt;
    logic [3:0]        prev;
    logic              step_ok;

    logic              push;
    evt_t              push_evt;
    logic              wrap_hit;
    logic              err_hit;

    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [EVT_W-1:0]  head_raw;
    evt_t              head;

    assign step_ok = (cnt_in == succ(prev));

    // State register, run flag and previous sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_INIT;
            run   <= 1'b0;
            prev  <= '0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
            prev  <= cnt_in;
        end
    end

    // Next state: run remembers one correct step already seen in SYNC.
    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        case (state)
            ST_INIT: begin
                state_nxt = ST_SYNC;
                run_nxt   = 1'b0;
            end
            ST_SYNC: begin
                if (step_ok && run) begin
                    state_nxt = ST_LOCK;
                    run_nxt   = 1'b0;
                end else begin
                    run_nxt = step_ok;
                end
            end
            ST_LOCK: begin
                if (!step_ok) begin
                    state_nxt = ST_SYNC;
                    run_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                run_nxt   = 1'b0;
            end
        endcase
    end

    // Event generation: at most one event per cycle.
    always_comb begin
        push     = 1'b0;
        push_evt = '0;
        wrap_hit = 1'b0;
        err_hit  = 1'b0;
        case (state)
            ST_SYNC: begin
                if (step_ok && run) begin
                    push     = 1'b1;
                    push_evt = '{code: EVT_LOCK, value: cnt_in};
                end
            end
            ST_LOCK: begin
                if (!step_ok) begin
                    err_hit  = 1'b1;
                    push     = 1'b1;
                    push_evt = '{code: EVT_ERR, value: cnt_in};
                end else if (prev == 4'hF) begin
                    wrap_hit = 1'b1;
                    push     = 1'b1;
                    push_evt = '{code: EVT_WRAP, value: cnt_in};
                end
            end
            default: begin
            end
        endcase
    end

    // Saturating counters and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrap_cnt <= '0;
            err_cnt  <= '0;
            ovf      <= 1'b0;
        end else begin
            if (wrap_hit && (wrap_cnt != '1)) begin
                wrap_cnt <= wrap_cnt + CNT_W'(1);
            end
            if (err_hit && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (push && fifo_full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    assign pop = evt_valid & evt_ready;

    evt_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (EVT_W)
    ) u_evt_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_evt),
        .pop       (pop),
        .pop_data  (head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head      = evt_t'(head_raw);
    assign locked    = (state == ST_LOCK);
    assign evt_valid = ~fifo_empty;
    // Stale storage is masked so an empty FIFO presents all-zero payload.
    assign evt_code  = evt_valid ? head.code  : '0;
    assign evt_value = evt_valid ? head.value : '0;

endmodule

// File: tb/tb_cnt_monitor.sv
// Directed, self-checking bench for cnt_monitor: vector table plus hand-written
// sequences for overflow, reset-while-busy and counter saturation.
module tb_cnt_monitor;

    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst;
    logic [3:0]       cnt_in;
    logic             locked;
    logic [CNT_W-1:0] wrap_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             ovf;
    logic             evt_valid;
    logic             evt_ready;
    logic [1:0]       evt_code;
    logic [3:0]       evt_value;

    cnt_monitor #(
        .FIFO_DEPTH (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_in    (cnt_in),
        .locked    (locked),
        .wrap_cnt  (wrap_cnt),
        .err_cnt   (err_cnt),
        .ovf       (ovf),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_value (evt_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] cnt;
        logic       rdy;
        logic       locked;
        logic [7:0] wrap;
        logic [7:0] err;
        logic       ovf;
        logic       valid;
        logic [1:0] code;
        logic [3:0] value;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(input int r, input int c, input int rd, input int lk,
                                input int w, input int e, input int ov, input int v,
                                input int code, input int val);
        vec_t t;
        t.rst    = 1'(r);
        t.cnt    = 4'(c);
        t.rdy    = 1'(rd);
        t.locked = 1'(lk);
        t.wrap   = 8'(w);
        t.err    = 8'(e);
        t.ovf    = 1'(ov);
        t.valid  = 1'(v);
        t.code   = 2'(code);
        t.value  = 4'(val);
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one sample, clock it in, then settle past the edge before checking.
    task automatic cyc(input logic r, input logic [3:0] c, input logic rd);
        rst       = r;
        cnt_in    = c;
        evt_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_evt(input string name, input int code, input int val);
        chk({name, ".valid"}, 32'(evt_valid), 32'(1));
        chk({name, ".code"},  32'(evt_code),  32'(code));
        chk({name, ".value"}, 32'(evt_value), 32'(val));
    endtask

    initial begin
        logic [3:0] v;
        int         raw_wraps;
        int         exp_heads_code[3];
        int         exp_heads_val[3];

        rst = 1'b0; cnt_in = '0; evt_ready = 1'b0;

        // Reset, lock, wrap, error, relock (ready held high so events drain).
        add(0, 0, 1,  0, 0, 0, 0,  0, 0, 0);
        add(0, 0, 1,  0, 0, 0, 0,  0, 0, 0);
        add(1, 0, 1,  0, 0, 0, 0,  0, 0, 0);
        add(1, 1, 1,  0, 0, 0, 0,  0, 0, 0);
        add(1, 2, 1,  1, 0, 0, 0,  1, 3, 2);
        add(1, 3, 1,  1, 0, 0, 0,  0, 0, 0);
        for (int c = 4; c <= 15; c++) add(1, c, 1,  1, 0, 0, 0,  0, 0, 0);
        add(1, 0, 1,  1, 1, 0, 0,  1, 1, 0);
        add(1, 1, 1,  1, 1, 0, 0,  0, 0, 0);
        for (int c = 2; c <= 5; c++) add(1, c, 1,  1, 1, 0, 0,  0, 0, 0);
        add(1, 7, 1,  0, 1, 1, 0,  1, 2, 7);
        add(1, 8, 1,  0, 1, 1, 0,  0, 0, 0);
        add(1, 9, 1,  1, 1, 1, 0,  1, 3, 9);
        add(1, 10, 1, 1, 1, 1, 0,  0, 0, 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].cnt, vecs[i].rdy);
            chk($sformatf("v%0d.locked", i), 32'(locked),    32'(vecs[i].locked));
            chk($sformatf("v%0d.wrap", i),   32'(wrap_cnt),  32'(vecs[i].wrap));
            chk($sformatf("v%0d.err", i),    32'(err_cnt),   32'(vecs[i].err));
            chk($sformatf("v%0d.ovf", i),    32'(ovf),       32'(vecs[i].ovf));
            chk($sformatf("v%0d.valid", i),  32'(evt_valid), 32'(vecs[i].valid));
            if (vecs[i].valid) begin
                chk($sformatf("v%0d.code", i),  32'(evt_code),  32'(vecs[i].code));
                chk($sformatf("v%0d.value", i), 32'(evt_value), 32'(vecs[i].value));
            end
        end

        // Overflow: five events with consumer stalled, fifth is dropped.
        cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(1, 13, 0); cyc(1, 14, 0);
        cyc(1, 15, 0);
        chk_evt("ovf.first", 3, 15);
        cyc(1, 0, 0);
        chk("ovf.wrap", 32'(wrap_cnt), 32'(1));
        cyc(1, 2, 0); cyc(1, 3, 0);
        cyc(1, 4, 0);
        chk("ovf.full_no_drop", 32'(ovf), 32'(0));
        cyc(1, 6, 0);
        chk("ovf.set", 32'(ovf), 32'(1));
        chk("ovf.err", 32'(err_cnt), 32'(2));
        chk("ovf.unlocked", 32'(locked), 32'(0));
        chk_evt("ovf.head", 3, 15);
        cyc(1, 6, 0);
        chk_evt("ovf.stable", 3, 15);
        exp_heads_code = '{1, 2, 3};
        exp_heads_val  = '{0, 2, 4};
        for (int k = 0; k < 3; k++) begin
            cyc(1, 6, 1);
            chk_evt($sformatf("ovf.drain%0d", k), exp_heads_code[k], exp_heads_val[k]);
        end
        cyc(1, 6, 1);
        chk("ovf.drained", 32'(evt_valid), 32'(0));
        chk("ovf.sticky", 32'(ovf), 32'(1));
        cyc(1, 6, 1);
        chk("ovf.pop_empty", 32'(evt_valid), 32'(0));

        // Reset with events pending, counters non-zero and a lock due in the reset cycle.
        cyc(0, 0, 0);
        cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 2, 0);
        for (int c = 3; c <= 15; c++) cyc(1, 4'(c), 0);
        cyc(1, 0, 0);
        cyc(1, 5, 0);
        cyc(1, 6, 0);
        chk("rst.pre_valid", 32'(evt_valid), 32'(1));
        chk("rst.pre_wrap",  32'(wrap_cnt),  32'(1));
        chk("rst.pre_err",   32'(err_cnt),   32'(1));
        cyc(0, 7, 0);
        chk("rst.locked", 32'(locked),    32'(0));
        chk("rst.wrap",   32'(wrap_cnt),  32'(0));
        chk("rst.err",    32'(err_cnt),   32'(0));
        chk("rst.ovf",    32'(ovf),       32'(0));
        chk("rst.valid",  32'(evt_valid), 32'(0));
        chk("rst.code",   32'(evt_code),  32'(0));
        chk("rst.value",  32'(evt_value), 32'(0));
        cyc(1, 1, 0);
        chk("rst.init_valid", 32'(evt_valid), 32'(0));
        cyc(1, 2, 0);
        chk("rst.init_not_step", 32'(locked), 32'(0));
        cyc(1, 3, 0);
        chk("rst.relock", 32'(locked), 32'(1));
        chk_evt("rst.relock_evt", 3, 3);

        // Error counting: constant input, then relock/error loop to saturation.
        cyc(0, 0, 1);
        cyc(1, 0, 1); cyc(1, 1, 1); cyc(1, 2, 1);
        chk("err.locked", 32'(locked), 32'(1));
        repeat (300) cyc(1, 2, 1);
        chk("err.const", 32'(err_cnt), 32'(1));
        chk("err.const_unlocked", 32'(locked), 32'(0));
        chk("err.const_valid", 32'(evt_valid), 32'(0));
        v = 4'd2;
        for (int i = 1; i <= 300; i++) begin
            cyc(1, v + 4'd1, 1);
            cyc(1, v + 4'd2, 1);
            if (i == 1) chk("err.loop_lock", 32'(locked), 32'(1));
            cyc(1, v + 4'd2, 1);
            v = v + 4'd2;
            if (i == 253) chk("err.pre_sat", 32'(err_cnt), 32'(254));
            if (i == 254) chk("err.sat", 32'(err_cnt), 32'(255));
        end
        chk("err.hold_sat", 32'(err_cnt), 32'(255));
        chk("err.no_wrap", 32'(wrap_cnt), 32'(0));
        chk("err.no_ovf", 32'(ovf), 32'(0));

        // Wrap counting to saturation while locked.
        cyc(0, 0, 1);
        cyc(1, 0, 1); cyc(1, 1, 1); cyc(1, 2, 1);
        v = 4'd3;
        raw_wraps = 0;
        for (int k = 0; k < 260 * 16; k++) begin
            cyc(1, v, 1);
            if (v == 4'd0) begin
                raw_wraps++;
                if (raw_wraps == 254) chk("wrap.pre_sat", 32'(wrap_cnt), 32'(254));
                if (raw_wraps == 255) chk("wrap.sat", 32'(wrap_cnt), 32'(255));
            end
            v = v + 4'd1;
        end
        chk("wrap.hold_sat", 32'(wrap_cnt), 32'(255));
        chk("wrap.no_err", 32'(err_cnt), 32'(0));
        chk("wrap.locked", 32'(locked), 32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
